// File: rtl/crop_pkg.sv
// Shared types and helpers for the crop/max capture stage that feeds the normalizer.
// The pixel type, state encoding and origin clamp live here so the top and the buffer agree.
package crop_pkg;

    typedef logic [7:0] pixel_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SYNC    = 3'd1,
        CAPTURE = 3'd2,
        DONE    = 3'd3,
        STREAM  = 3'd4
    } state_t;

    localparam int DEF_IN_ROWS  = 16;
    localparam int DEF_IN_COLS  = 16;
    localparam int DEF_OUT_ROWS = 10;
    localparam int DEF_OUT_COLS = 10;

    function automatic int unsigned buf_depth(input int unsigned rows, input int unsigned cols);
        return rows * cols;
    endfunction

    function automatic int unsigned addr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Keeps the window fully inside the raw frame by pulling the origin back if needed.
    function automatic int unsigned clamp_origin(input int unsigned req, input int unsigned limit);
        return (req > limit) ? limit : req;
    endfunction

endpackage

// File: rtl/crop_buffer.sv
// Simple dual-port pixel RAM holding the cropped window.
// Synchronous write, registered read with one cycle of latency, array left unreset.
module crop_buffer
    import crop_pkg::*;
#(
    parameter int DEPTH = 100,
    parameter int AW    = 7
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  pixel_t        wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output pixel_t        rd_data
);

    pixel_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/crop_max_filter.sv
// Captures a programmable window of a raw 8-bit frame, reports its maximum on ap_done,
// then streams the buffered crop out in raster order.
module crop_max_filter
    import crop_pkg::*;
#(
    parameter int IN_ROWS  = DEF_IN_ROWS,
    parameter int IN_COLS  = DEF_IN_COLS,
    parameter int OUT_ROWS = DEF_OUT_ROWS,
    parameter int OUT_COLS = DEF_OUT_COLS
) (
    input  logic                       clk,
    input  logic                       srst,
    input  logic                       ap_start,
    output logic                       ap_idle,
    output logic                       ap_ready,
    output logic                       ap_done,
    input  logic [$clog2(IN_ROWS)-1:0] crop_row,
    input  logic [$clog2(IN_COLS)-1:0] crop_col,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    input  logic [7:0]                 s_axis_tdata,
    input  logic                       s_axis_tuser,
    output logic [7:0]                 max_value,
    output logic                       max_value_tvalid,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic [7:0]                 m_axis_tdata,
    output logic                       m_axis_tlast
);

    localparam int RW    = $clog2(IN_ROWS);
    localparam int CW    = $clog2(IN_COLS);
    localparam int DEPTH = buf_depth(OUT_ROWS, OUT_COLS);
    localparam int AW    = addr_width(DEPTH);

    state_t        state;
    logic [RW-1:0] row_cnt;
    logic [CW-1:0] col_cnt;
    logic [RW-1:0] org_row;
    logic [CW-1:0] org_col;
    pixel_t        run_max;
    pixel_t        max_q;

    logic          s_hs;
    logic          capture_beat;
    logic [RW-1:0] pix_row;
    logic [CW-1:0] pix_col;
    logic [RW-1:0] rel_row;
    logic [CW-1:0] rel_col;
    logic          in_win;
    logic          last_pix;
    pixel_t        base_max;
    pixel_t        win_max;
    logic [AW-1:0] wr_addr;
    logic          wr_en;

    logic [AW-1:0] rd_addr;
    logic          rd_all;
    logic          rd_en;
    logic          inflight;
    logic          inflight_last;
    pixel_t        ram_q;
    logic          out_valid;
    logic          out_last;
    pixel_t        out_data;
    logic          pf_valid;
    logic          pf_last;
    pixel_t        pf_data;
    logic          pop;
    logic [1:0]    occ;

    assign ap_idle          = (state == IDLE);
    assign ap_ready         = (state == IDLE);
    assign ap_done          = (state == DONE);
    assign max_value_tvalid = (state == DONE);
    assign max_value        = max_q;
    assign s_axis_tready    = (state == SYNC) || (state == CAPTURE);

    // A tuser beat always counts as pixel (0,0), both for the first SOF and for a mid-frame restart.
    assign s_hs         = s_axis_tvalid && s_axis_tready;
    assign capture_beat = s_hs && ((state == CAPTURE) || s_axis_tuser);
    assign pix_row      = s_axis_tuser ? '0 : row_cnt;
    assign pix_col      = s_axis_tuser ? '0 : col_cnt;
    assign rel_row      = pix_row - org_row;
    assign rel_col      = pix_col - org_col;
    assign in_win       = (pix_row >= org_row) && (32'(rel_row) < OUT_ROWS) &&
                          (pix_col >= org_col) && (32'(rel_col) < OUT_COLS);
    assign last_pix     = (pix_row == RW'(IN_ROWS - 1)) && (pix_col == CW'(IN_COLS - 1));
    assign base_max     = s_axis_tuser ? '0 : run_max;
    assign win_max      = (in_win && (s_axis_tdata > base_max)) ? s_axis_tdata : base_max;
    assign wr_addr      = AW'(rel_row) * AW'(OUT_COLS) + AW'(rel_col);
    assign wr_en        = capture_beat && in_win;

    // Frame control: origin latch, raster counters, running max and the reported max.
    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            state   <= IDLE;
            row_cnt <= '0;
            col_cnt <= '0;
            org_row <= '0;
            org_col <= '0;
            run_max <= '0;
            max_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ap_start) begin
                        org_row <= RW'(clamp_origin(32'(crop_row), IN_ROWS - OUT_ROWS));
                        org_col <= CW'(clamp_origin(32'(crop_col), IN_COLS - OUT_COLS));
                        run_max <= '0;
                        row_cnt <= '0;
                        col_cnt <= '0;
                        state   <= SYNC;
                    end
                end
                SYNC, CAPTURE: begin
                    if (capture_beat) begin
                        run_max <= win_max;
                        if (last_pix) begin
                            max_q <= (win_max == '0) ? pixel_t'(1) : win_max;
                            state <= DONE;
                        end else begin
                            state <= CAPTURE;
                            if (pix_col == CW'(IN_COLS - 1)) begin
                                col_cnt <= '0;
                                row_cnt <= pix_row + 1'b1;
                            end else begin
                                col_cnt <= pix_col + 1'b1;
                                row_cnt <= pix_row;
                            end
                        end
                    end
                end
                DONE: begin
                    state <= STREAM;
                end
                STREAM: begin
                    if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    crop_buffer #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_buffer (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (s_axis_tdata),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (ram_q)
    );

    // Output register plus one prefetch entry: a read is issued only if its data is guaranteed a slot.
    assign pop   = out_valid && m_axis_tready;
    assign occ   = {1'b0, out_valid} + {1'b0, pf_valid} + {1'b0, inflight};
    assign rd_en = (state == STREAM) && !rd_all && ((occ - {1'b0, pop}) < 2'd2);

    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            rd_addr       <= '0;
            rd_all        <= 1'b0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            out_valid     <= 1'b0;
            out_last      <= 1'b0;
            out_data      <= '0;
            pf_valid      <= 1'b0;
            pf_last       <= 1'b0;
            pf_data       <= '0;
        end else if (state != STREAM) begin
            rd_addr       <= '0;
            rd_all        <= 1'b0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            out_valid     <= 1'b0;
            out_last      <= 1'b0;
            pf_valid      <= 1'b0;
            pf_last       <= 1'b0;
        end else begin
            inflight      <= rd_en;
            inflight_last <= rd_en && (rd_addr == AW'(DEPTH - 1));
            if (rd_en) begin
                if (rd_addr == AW'(DEPTH - 1)) begin
                    rd_all <= 1'b1;
                end else begin
                    rd_addr <= rd_addr + 1'b1;
                end
            end
            if (!out_valid || pop) begin
                if (pf_valid) begin
                    out_valid <= 1'b1;
                    out_data  <= pf_data;
                    out_last  <= pf_last;
                    pf_valid  <= inflight;
                    pf_data   <= ram_q;
                    pf_last   <= inflight_last;
                end else begin
                    out_valid <= inflight;
                    out_data  <= ram_q;
                    out_last  <= inflight_last;
                end
            end else if (inflight) begin
                pf_valid <= 1'b1;
                pf_data  <= ram_q;
                pf_last  <= inflight_last;
            end
        end
    end

    assign m_axis_tvalid = out_valid;
    assign m_axis_tdata  = out_data;
    assign m_axis_tlast  = out_last;

endmodule

// File: doc/crop_max_filter.md
Name: crop_max_filter

Overview:
- Upstream neighbour of the normalization stage.
- Accepts a full raw 8-bit camera frame on AXI-Stream and keeps a programmable OUT_ROWS x OUT_COLS window in an internal buffer, tracking the window's maximum pixel.
- When the frame completes, it pulses ap_done and presents max_value as the normalization denominator, then streams the buffered crop out.
- This ordering guarantees the downstream normalizer sees a final max before the first pixel.

Parameters:
- IN_ROWS, 16: raw frame rows.
- IN_COLS, 16: raw frame columns.
- OUT_ROWS, 10: crop rows; must satisfy OUT_ROWS <= IN_ROWS.
- OUT_COLS, 10: crop columns; must satisfy OUT_COLS <= IN_COLS.

Ports:
- clk  in  1  clock.
- srst  in  1  reset; asynchronous, active-high.
- ap_start  in  1  start one frame; accepted only when ap_idle=1.
- ap_idle  out  1  high in IDLE.
- ap_ready  out  1  high in IDLE.
- ap_done  out  1  one-cycle pulse when capture completes.
- crop_row  in  $clog2(IN_ROWS)  window top row; latched on accepted ap_start.
- crop_col  in  $clog2(IN_COLS)  window left column; latched on accepted ap_start.
- s_axis_tvalid  in  1  raw pixel valid.
- s_axis_tready  out  1  raw pixel ready.
- s_axis_tdata  in  8  raw pixel.
- s_axis_tuser  in  1  start-of-frame, marking pixel (0,0).
- max_value  out  8  window maximum, held until the next capture.
- max_value_tvalid  out  1  one-cycle pulse, coincident with ap_done.
- m_axis_tvalid  out  1  cropped pixel valid.
- m_axis_tready  in  1  cropped pixel ready.
- m_axis_tdata  out  8  cropped pixel, raster order.
- m_axis_tlast  out  1  high on the last cropped pixel.

Behaviour:
- Reset (async, any state):
  - State goes to IDLE; counters and running max clear.
  - Outputs: ap_idle=1, ap_ready=1, ap_done=0, max_value=0, max_value_tvalid=0, m_axis_tvalid=0, m_axis_tlast=0, s_axis_tready=0.
  - Buffer contents are don't-care.
- FSM states: IDLE, SYNC, CAPTURE, DONE, STREAM.
- IDLE:
  - s_axis_tready=0.
  - ap_start=1 -> latch crop origin, clear max and counters, go to SYNC.
  - Latched origin is clamped: crop_row to min(crop_row, IN_ROWS-OUT_ROWS); crop_col likewise against IN_COLS-OUT_COLS.
- SYNC:
  - s_axis_tready=1; accepted beats with tuser=0 are discarded.
  - A beat with tuser=1 is processed as pixel (0,0); go to CAPTURE.
- CAPTURE:
  - s_axis_tready=1 always; no upstream backpressure.
  - Each handshake advances col; col wraps at IN_COLS-1 and increments row.
  - A pixel inside the window is written to buffer address (row-crop_row)*OUT_COLS + (col-crop_col), and max = max(max, pixel).
  - A tuser=1 beat mid-frame restarts the frame: counters and max clear, and that beat is pixel (0,0).
  - The handshake on pixel (IN_ROWS-1, IN_COLS-1) moves to DONE on the next cycle.
- DONE (exactly one cycle):
  - ap_done=1 and max_value_tvalid=1.
  - max_value = running max, forced to 1 when the max is 0 (avoids divide-by-zero downstream).
  - Go to STREAM.
- STREAM:
  - s_axis_tready=0.
  - The buffer is read in address order through a one-entry prefetch register, so RAM read latency of 1 is hidden.
  - m_axis_tvalid rises no later than 2 cycles after entering STREAM.
  - Under continuous m_axis_tready, throughput is one pixel per cycle with no bubbles.
  - tdata, tvalid and tlast stay stable while tvalid=1 and tready=0.
  - tlast=1 on beat OUT_ROWS*OUT_COLS-1.
  - The handshake with tlast=1 returns to IDLE next cycle.
- ap_start outside IDLE is ignored.
- Counters are sized with $clog2 of their range. Addresses are computed without overflow at max parameters, using width $clog2(OUT_ROWS*OUT_COLS).

Decomposition:
- crop_pkg:
  - state enum type.
  - pixel_t (logic [7:0]).
  - Depth/width localparams derived from the parameters.
  - Clamp function for the crop origin.
- Sub-module crop_buffer: simple dual-port RAM, OUT_ROWS*OUT_COLS x 8, synchronous write, registered read with 1-cycle latency, no reset on the array.

Test Plan:
- IN 8x8, OUT 4x4, crop (2,3), pixel = row*8+col, tready=1 -> ap_done and max_value_tvalid pulse together with max_value=46; stream is 19,20,21,22,27,...,46; tlast on 46; 16 beats with no bubbles.
- Same frame, crop (7,7) -> clamped to (4,4); first pixel 36, last 63, max 63.
- All-zero frame -> max_value=1; sixteen 0 output beats.
- Two garbage beats (tuser=0) before SOF, plus a second tuser=1 at raw pixel 20 followed by a full frame -> garbage and the aborted partial frame are ignored; output matches scenario 1.
- Random m_axis_tready at 30% duty during STREAM -> data held stable while stalled; sequence identical to scenario 1; ap_start pulses during STREAM are ignored.
- srst asserted mid-CAPTURE and mid-STREAM -> outputs immediately take their reset values; a fresh ap_start then yields correct results.
